bcd_sequence_controller: RTL and testbench

Run/pause/step sequencer for the single-digit BCD display counter. It runs in the divided display-clock domain (clk_out) and owns the digit register. It decides when the digit advances, in which direction, and what happens at the range limits (wrap or bounce with dwell). Its count output feeds the existing BCD-to-7-segment decoder; its status outputs drive the DP/LED indicators.

---
 rtl/bcd_seq_pkg.sv | 18 +
 rtl/bcd_step_unit.sv | 31 +++
 rtl/bcd_sequence_controller.sv | 157 +++++++++++++++
 tb/tb_bcd_sequence_controller.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bcd_seq_pkg.sv
// Shared encodings for the BCD display sequencer: FSM states, limit modes
// and count directions.
package bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DWELL = 2'd3
  } seq_state_t;

  localparam logic MODE_WRAP   = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/bcd_step_unit.sv
// Combinational one-digit advance: works out the next digit, whether the
// current digit sits on the limit in the travel direction, and whether to reverse.
module bcd_step_unit
  import bcd_seq_pkg::*;
#(
  parameter logic [3:0] MIN_DIGIT = 4'd0,
  parameter logic [3:0] MAX_DIGIT = 4'd9
) (
  input  logic [3:0] count,
  input  logic       dir,
  input  logic       mode,
  output logic [3:0] next_count,
  output logic       at_limit,
  output logic       flip_dir
);

  always_comb begin
    at_limit   = (dir == DIR_UP) ? (count >= MAX_DIGIT) : (count <= MIN_DIGIT);
    flip_dir   = at_limit && (mode == MODE_BOUNCE);
    next_count = count;
    if (!at_limit) begin
      next_count = (dir == DIR_UP) ? count + 4'd1 : count - 4'd1;
    end else if (mode == MODE_WRAP) begin
      next_count = (dir == DIR_UP) ? MIN_DIGIT : MAX_DIGIT;
    end else begin
      // Bounce reverses first, so the digit steps away from the limit.
      next_count = (dir == DIR_UP) ? count - 4'd1 : count + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_sequence_controller.sv
// Run/pause/step sequencer owning the single BCD display digit.
//   state | meaning
//   IDLE  | stopped; step advances once, stop reloads MIN_DIGIT
//   RUN   | advancing one digit per clk_out edge
//   PAUSE | held mid-sequence; step advances once, stop returns to IDLE
//   DWELL | bounce mode holding at a limit for HOLD_TICKS extra cycles
module bcd_sequence_controller
  import bcd_seq_pkg::*;
#(
  parameter logic [3:0] MIN_DIGIT  = 4'd0,
  parameter logic [3:0] MAX_DIGIT  = 4'd9,
  parameter int         HOLD_TICKS = 3
) (
  input  logic       clk_out,
  input  logic       reset,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       step_i,
  input  logic       dir_i,
  input  logic       mode_i,
  output logic [3:0] count_o,
  output logic [1:0] state_o,
  output logic       busy_o,
  output logic       limit_pulse_o
);

  if (!((MIN_DIGIT < MAX_DIGIT) && (MAX_DIGIT <= 4'd9))) begin : g_bad_digit_range
    $error("bcd_sequence_controller: need MIN_DIGIT < MAX_DIGIT <= 9");
  end
  if ((HOLD_TICKS < 0) || (HOLD_TICKS > 15)) begin : g_bad_hold_ticks
    $error("bcd_sequence_controller: HOLD_TICKS must be 0..15");
  end

  localparam bit         HAS_DWELL  = (HOLD_TICKS != 0);
  localparam logic [3:0] DWELL_LAST = 4'(HOLD_TICKS - 1);

  seq_state_t state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [3:0] dwell_q, dwell_d;
  logic       dir_q, dir_d;
  logic       pulse_q, pulse_d;
  logic       busy_q, busy_d;

  logic       su_dir, su_mode;
  logic [3:0] su_next;
  logic       su_at_limit, su_flip;
  logic       adv_dir;

  // DWELL always finishes as a bounce along the already-flipped dir_q, even
  // if mode_i changed meanwhile; wrap mode tracks dir_i live.
  assign su_mode = (state_q == ST_DWELL) ? MODE_BOUNCE : mode_i;
  assign su_dir  = (state_q == ST_DWELL)                            ? dir_q :
                   (mode_i == MODE_WRAP || state_q == ST_IDLE)      ? dir_i : dir_q;
  assign adv_dir = su_flip ? ~su_dir : su_dir;

  bcd_step_unit #(
    .MIN_DIGIT (MIN_DIGIT),
    .MAX_DIGIT (MAX_DIGIT)
  ) u_step (
    .count      (count_q),
    .dir        (su_dir),
    .mode       (su_mode),
    .next_count (su_next),
    .at_limit   (su_at_limit),
    .flip_dir   (su_flip)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dwell_d = dwell_q;
    pulse_d = 1'b0;
    dir_d   = (mode_i == MODE_WRAP && state_q != ST_DWELL) ? dir_i : dir_q;

    case (state_q)
      ST_IDLE: begin
        if (stop_i) begin
          count_d = MIN_DIGIT;
        end else if (start_i) begin
          state_d = ST_RUN;
          dir_d   = dir_i;
        end else if (step_i) begin
          count_d = su_next;
          dir_d   = adv_dir;
          pulse_d = su_at_limit;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_PAUSE;
        end else if (HAS_DWELL && su_flip) begin
          state_d = ST_DWELL;
          dir_d   = adv_dir;
          dwell_d = 4'd0;
          pulse_d = 1'b1;
        end else begin
          count_d = su_next;
          dir_d   = adv_dir;
          pulse_d = su_at_limit;
        end
      end
      ST_DWELL: begin
        if (stop_i) begin
          state_d = ST_PAUSE;
          dwell_d = 4'd0;
        end else if (dwell_q == DWELL_LAST) begin
          state_d = ST_RUN;
          dwell_d = 4'd0;
          count_d = su_next;
          dir_d   = adv_dir;
          pulse_d = su_at_limit;
        end else begin
          dwell_d = dwell_q + 4'd1;
        end
      end
      ST_PAUSE: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          count_d = MIN_DIGIT;
        end else if (start_i) begin
          state_d = ST_RUN;
        end else if (step_i) begin
          count_d = su_next;
          dir_d   = adv_dir;
          pulse_d = su_at_limit;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DWELL);
  end

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= MIN_DIGIT;
      dwell_q <= 4'd0;
      dir_q   <= DIR_UP;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dwell_q <= dwell_d;
      dir_q   <= dir_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  assign count_o       = count_q;
  assign state_o       = state_q;
  assign busy_o        = busy_q;
  assign limit_pulse_o = pulse_q;

endmodule

// File: tb/tb_bcd_sequence_controller.sv
// Directed bench for bcd_sequence_controller (MIN 0, MAX 9, HOLD_TICKS 3).
module tb_bcd_sequence_controller;

  logic       clk_out = 1'b0;
  logic       reset;
  logic       start_i, stop_i, step_i, dir_i, mode_i;
  logic [3:0] count_o;
  logic [1:0] state_o;
  logic       busy_o, limit_pulse_o;

  int n_assert = 0;
  int n_fail   = 0;

  bcd_sequence_controller #(
    .MIN_DIGIT  (4'd0),
    .MAX_DIGIT  (4'd9),
    .HOLD_TICKS (3)
  ) dut (
    .clk_out       (clk_out),
    .reset         (reset),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .step_i        (step_i),
    .dir_i         (dir_i),
    .mode_i        (mode_i),
    .count_o       (count_o),
    .state_o       (state_o),
    .busy_o        (busy_o),
    .limit_pulse_o (limit_pulse_o)
  );

  always #5 clk_out = ~clk_out;

  task automatic tick();
    @(posedge clk_out);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] cnt, input logic [1:0] st,
                         input logic busy, input logic pulse);
    chk({tag, ".count"}, count_o, cnt);
    chk({tag, ".state"}, {2'b00, state_o}, {2'b00, st});
    chk({tag, ".busy"}, {3'b000, busy_o}, {3'b000, busy});
    chk({tag, ".pulse"}, {3'b000, limit_pulse_o}, {3'b000, pulse});
  endtask

  // Single-edge pulse on one or more controls, then release them.
  task automatic pulse_in(input logic st, input logic sp, input logic se);
    start_i = st; stop_i = sp; step_i = se;
    tick();
    start_i = 1'b0; stop_i = 1'b0; step_i = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    start_i = 1'b0; stop_i = 1'b0; step_i = 1'b0;
    dir_i = 1'b1; mode_i = 1'b0;
    tick(); tick();
    chk_all("reset", 4'd0, 2'd0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    chk_all("idle_after_reset", 4'd0, 2'd0, 1'b0, 1'b0);

    // Wrap up from the start edge: no advance on the start edge itself.
    pulse_in(1'b1, 1'b0, 1'b0);
    chk_all("start_edge", 4'd0, 2'd1, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_all($sformatf("wrap_up%0d", i), 4'(i % 10), 2'd1, 1'b1, i == 10);
    end

    // Wrap down follows dir_i immediately.
    dir_i = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk_all($sformatf("wrap_dn%0d", i), 4'((20 - i) % 10), 2'd1, 1'b1, (i == 1) || (i == 11));
    end

    // Back to IDLE via PAUSE.
    pulse_in(1'b0, 1'b1, 1'b0);
    chk_all("run_stop", 4'd9, 2'd2, 1'b0, 1'b0);
    pulse_in(1'b0, 1'b1, 1'b0);
    chk_all("pause_stop", 4'd0, 2'd0, 1'b0, 1'b0);

    // Bounce with dwell; dir_i is ignored once running.
    mode_i = 1'b1; dir_i = 1'b1;
    pulse_in(1'b1, 1'b0, 1'b0);
    dir_i = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk_all("bounce_at7", 4'd7, 2'd1, 1'b1, 1'b0);
    tick(); chk_all("bounce_8",  4'd8, 2'd1, 1'b1, 1'b0);
    tick(); chk_all("bounce_9a", 4'd9, 2'd1, 1'b1, 1'b0);
    tick(); chk_all("bounce_9b", 4'd9, 2'd3, 1'b1, 1'b1);
    tick(); chk_all("bounce_9c", 4'd9, 2'd3, 1'b1, 1'b0);
    tick(); chk_all("bounce_9d", 4'd9, 2'd3, 1'b1, 1'b0);
    tick(); chk_all("bounce_8r", 4'd8, 2'd1, 1'b1, 1'b0);
    tick(); chk_all("bounce_7r", 4'd7, 2'd1, 1'b1, 1'b0);
    tick(); tick();
    chk_all("bounce_5r", 4'd5, 2'd1, 1'b1, 1'b0);

    // Pause at 5, switch to wrap-up and step three times.
    mode_i = 1'b0; dir_i = 1'b1;
    pulse_in(1'b0, 1'b1, 1'b0);
    chk_all("pause_hold", 4'd5, 2'd2, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      pulse_in(1'b0, 1'b0, 1'b1);
      chk_all($sformatf("pause_step%0d", i), 4'(5 + i), 2'd2, 1'b0, 1'b0);
    end
    pulse_in(1'b0, 1'b1, 1'b0);
    chk_all("pause_clear", 4'd0, 2'd0, 1'b0, 1'b0);

    // Simultaneous pulses.
    pulse_in(1'b1, 1'b0, 1'b1);
    chk_all("idle_start_step", 4'd0, 2'd1, 1'b1, 1'b0);
    tick();
    chk_all("run_after_both", 4'd1, 2'd1, 1'b1, 1'b0);
    pulse_in(1'b1, 1'b1, 1'b0);
    chk_all("run_stop_start", 4'd1, 2'd2, 1'b0, 1'b0);
    pulse_in(1'b1, 1'b1, 1'b1);
    chk_all("pause_all_three", 4'd0, 2'd0, 1'b0, 1'b0);

    // Steps from IDLE at the lower limit.
    mode_i = 1'b1; dir_i = 1'b0;
    pulse_in(1'b0, 1'b0, 1'b1);
    chk_all("idle_bounce_step", 4'd1, 2'd0, 1'b0, 1'b1);
    mode_i = 1'b0;
    pulse_in(1'b0, 1'b0, 1'b1);
    chk_all("idle_wrap_step0", 4'd0, 2'd0, 1'b0, 1'b0);
    pulse_in(1'b0, 1'b0, 1'b1);
    chk_all("idle_wrap_step9", 4'd9, 2'd0, 1'b0, 1'b1);
    pulse_in(1'b0, 1'b1, 1'b0);
    chk_all("idle_stop_reload", 4'd0, 2'd0, 1'b0, 1'b0);

    // Stop during DWELL keeps the reversed direction.
    mode_i = 1'b1; dir_i = 1'b1;
    pulse_in(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk_all("dwell_enter", 4'd9, 2'd3, 1'b1, 1'b1);
    pulse_in(1'b0, 1'b1, 1'b0);
    chk_all("dwell_stop", 4'd9, 2'd2, 1'b0, 1'b0);
    pulse_in(1'b0, 1'b0, 1'b1);
    chk_all("dwell_stop_step", 4'd8, 2'd2, 1'b0, 1'b0);

    // Asynchronous reset in the middle of DWELL.
    pulse_in(1'b0, 1'b1, 1'b0);
    pulse_in(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk_all("dwell_again", 4'd9, 2'd3, 1'b1, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_all("async_reset", 4'd0, 2'd0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    tick();
    chk_all("post_reset", 4'd0, 2'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
